// File: rtl/rob_pkg.sv
// Shared ROB types and sizing for rename, execute and the reorder buffer itself.
// Entry layout, tag/pointer typedefs and an entry constructor.
package rob_pkg;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 7;
    localparam int PC_W   = 9;
    localparam int TAG_W  = $clog2(DEPTH);

    typedef logic [TAG_W-1:0] rob_tag_t;
    typedef logic [TAG_W:0]   rob_ptr_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [4:0]        rd;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] old_prd;
        logic [PC_W-1:0]   pc;
    } rob_entry_t;

    localparam rob_entry_t ROB_ENTRY_CLR = rob_entry_t'({$bits(rob_entry_t){1'b0}});

    function automatic rob_entry_t make_entry(
        input logic              has_dest,
        input logic [4:0]        rd,
        input logic [PREG_W-1:0] prd,
        input logic [PREG_W-1:0] old_prd,
        input logic [PC_W-1:0]   pc
    );
        rob_entry_t e;
        e.valid    = 1'b1;
        e.done     = 1'b0;
        e.has_dest = has_dest;
        e.rd       = rd;
        e.prd      = prd;
        e.old_prd  = old_prd;
        e.pc       = pc;
        return e;
    endfunction

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Wrap-around ROB pointer with a phase bit above the index; load takes priority over inc.
module rob_ptr
    import rob_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     inc,
    input  logic     load,
    input  rob_ptr_t load_val,
    output rob_ptr_t ptr_q
);

    rob_ptr_t ptr_d;

    // Next pointer: DEPTH is a power of two, so the carry into the top bit is the phase toggle.
    always_comb begin
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ptr_q + rob_ptr_t'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= {(TAG_W+1){1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, completes by tag, retires from head, squashes on flush.
// Optional ROB_STATS_EN adds saturating perf_commits / perf_full_cycles counters.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dest,
    input  logic [4:0]        alloc_rd,
    input  logic [PREG_W-1:0] alloc_prd,
    input  logic [PREG_W-1:0] alloc_old_prd,
    input  logic [PC_W-1:0]   alloc_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic              flush_valid,
    input  logic [TAG_W-1:0]  flush_tag,
    output logic              commit_en,
    output logic              commit_has_dest,
    output logic [4:0]        commit_rd,
    output logic [PREG_W-1:0] commit_prd,
    output logic [PREG_W-1:0] commit_old_preg,
    output logic [PC_W-1:0]   commit_pc,
    output logic [TAG_W:0]    rob_count
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]       perf_commits,
    output logic [31:0]       perf_full_cycles
`endif
);

    localparam rob_ptr_t DEPTH_CNT = rob_ptr_t'(DEPTH);

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];
    rob_ptr_t   head_q, tail_q, tail_load_s, keep_cnt_s;
    rob_tag_t   head_idx_s;
    logic       full_s, empty_s, flush_hit_s, alloc_fire_s, cdb_hit_s;
    logic [DEPTH-1:0] squash_s;

    rob_ptr u_head (
        .clk      (clk),
        .reset    (reset),
        .inc      (commit_en),
        .load     (1'b0),
        .load_val ({(TAG_W+1){1'b0}}),
        .ptr_q    (head_q)
    );

    rob_ptr u_tail (
        .clk      (clk),
        .reset    (reset),
        .inc      (alloc_fire_s),
        .load     (flush_hit_s),
        .load_val (tail_load_s),
        .ptr_q    (tail_q)
    );

    // Occupancy, handshakes and flush window; survivors are head..flush_tag inclusive.
    always_comb begin
        rob_count    = tail_q - head_q;
        full_s       = (rob_count == DEPTH_CNT);
        empty_s      = (rob_count == {(TAG_W+1){1'b0}});
        alloc_ready  = !full_s && !reset;
        alloc_tag    = tail_q[TAG_W-1:0];
        head_idx_s   = head_q[TAG_W-1:0];
        flush_hit_s  = flush_valid && entries_q[flush_tag].valid;
        keep_cnt_s   = {1'b0, rob_tag_t'(flush_tag - head_idx_s)} + rob_ptr_t'(1);
        tail_load_s  = head_q + keep_cnt_s;
        alloc_fire_s = alloc_valid && alloc_ready && !flush_hit_s;
        commit_en    = !reset && !empty_s && entries_q[head_idx_s].valid &&
                       entries_q[head_idx_s].done && !flush_valid;
        for (int i = 0; i < DEPTH; i++) begin
            squash_s[i] = flush_hit_s &&
                ({1'b0, rob_tag_t'(rob_tag_t'(i) - head_idx_s)} >= keep_cnt_s);
        end
        cdb_hit_s = cdb_valid && entries_q[cdb_tag].valid && !squash_s[cdb_tag];
    end

    // Retirement port mirrors the head entry only while it actually retires.
    always_comb begin
        if (commit_en) begin
            commit_has_dest = entries_q[head_idx_s].has_dest;
            commit_rd       = entries_q[head_idx_s].rd;
            commit_prd      = entries_q[head_idx_s].prd;
            commit_old_preg = entries_q[head_idx_s].old_prd;
            commit_pc       = entries_q[head_idx_s].pc;
        end else begin
            commit_has_dest = 1'b0;
            commit_rd       = 5'd0;
            commit_prd      = {PREG_W{1'b0}};
            commit_old_preg = {PREG_W{1'b0}};
            commit_pc       = {PC_W{1'b0}};
        end
    end

    // Entry next-state: completion, squash, retirement clear, then allocation write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (cdb_hit_s && (cdb_tag == rob_tag_t'(i))) begin
                entries_d[i].done = 1'b1;
            end else begin
                entries_d[i].done = entries_q[i].done;
            end
            if (squash_s[i]) begin
                entries_d[i] = ROB_ENTRY_CLR;
            end else begin
                entries_d[i].valid = entries_q[i].valid;
            end
        end
        if (commit_en) begin
            entries_d[head_idx_s] = ROB_ENTRY_CLR;
        end else begin
            entries_d[head_idx_s].valid = entries_d[head_idx_s].valid;
        end
        if (alloc_fire_s) begin
            entries_d[tail_q[TAG_W-1:0]] = make_entry(alloc_has_dest, alloc_rd, alloc_prd,
                                                      alloc_old_prd, alloc_pc);
        end else begin
            entries_d[tail_q[TAG_W-1:0]].valid = entries_d[tail_q[TAG_W-1:0]].valid;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= ROB_ENTRY_CLR;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

`ifdef ROB_STATS_EN
    logic [31:0] perf_commits_q, perf_commits_d, perf_full_q, perf_full_d;

    // Saturating event counters.
    always_comb begin
        if (commit_en && (perf_commits_q != 32'hFFFF_FFFF)) begin
            perf_commits_d = perf_commits_q + 32'd1;
        end else begin
            perf_commits_d = perf_commits_q;
        end
        if (alloc_valid && full_s && (perf_full_q != 32'hFFFF_FFFF)) begin
            perf_full_d = perf_full_q + 32'd1;
        end else begin
            perf_full_d = perf_full_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_commits_q <= 32'd0;
            perf_full_q    <= 32'd0;
        end else begin
            perf_commits_q <= perf_commits_d;
            perf_full_q    <= perf_full_d;
        end
    end

    assign perf_commits     = perf_commits_q;
    assign perf_full_cycles = perf_full_q;
`endif

endmodule
